// File: rtl/keypad_scanner.sv
// 4x4 column-multiplexed keypad reader: scans columns, debounces whole-scan results,
// rejects ghost/multi-press. Define KEYPAD_SCANNER_AUTOREPEAT_EN for held-key auto-repeat.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int unsigned DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [4:0]  NONE = 5'b0_0000;

    if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS == 0 || REPEAT_SCANS == 0) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          scan_done_q, scan_done_d;
    logic [4:0]    prev_q, prev_d;      // {is_key, code}; NONE is all zero
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          sample_c;
    logic [1:0]    cnt_c;
    logic [3:0]    code_c;
    logic [4:0]    scan_res_c;
    logic          accept_c;

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
    localparam int unsigned RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    logic [RW-1:0] rep_q, rep_d;
`endif

    // Scan sequencing, per-scan accumulation, debounce and acceptance
    always_comb begin
        dwell_d     = dwell_q + DW'(1);
        col_idx_d   = col_idx_q;
        col_d       = col_q;
        acc_cnt_d   = acc_cnt_q;
        acc_code_d  = acc_code_q;
        scan_done_d = 1'b0;
        prev_d      = prev_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        scan_res_c  = NONE;
        sample_c    = (dwell_q == DW'(SETTLE_CYCLES - 1));

        cnt_c  = acc_cnt_q;
        code_c = acc_code_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                cnt_c  = (cnt_c == 2'd2) ? 2'd2 : cnt_c + 2'd1;
                code_c = {2'(r), col_idx_q};
            end
        end

        if (sample_c) begin
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
            if (col_idx_q == 2'd3) begin
                acc_cnt_d   = '0;
                acc_code_d  = '0;
                scan_done_d = 1'b1;
                scan_res_c  = (cnt_c == 2'd1) ? {1'b1, code_c} : NONE;
                prev_d      = scan_res_c;
                if (scan_res_c == prev_q)
                    stable_d = (stable_q == SW'(DEBOUNCE_SCANS)) ? stable_q : stable_q + SW'(1);
                else
                    stable_d = SW'(1);
            end else begin
                acc_cnt_d  = cnt_c;
                acc_code_d = code_c;
            end
        end

        // Accept only a stable result that differs from the current accepted state
        accept_c = scan_done_q && (stable_q == SW'(DEBOUNCE_SCANS)) &&
                   ((prev_q[4] != key_held_q) || (prev_q[4] && (prev_q[3:0] != key_code_q)));
        if (accept_c) begin
            key_held_d = prev_q[4];
            if (prev_q[4]) begin
                key_code_d  = prev_q[3:0];
                key_valid_d = 1'b1;
            end
        end

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
        rep_d = rep_q;
        if (scan_done_q) begin
            if (accept_c || !key_held_q) begin
                rep_d = '0;
            end else if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                rep_d       = '0;
                key_valid_d = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= '0;
            col_q       <= 4'b1110;
            acc_cnt_q   <= '0;
            acc_code_q  <= '0;
            scan_done_q <= 1'b0;
            prev_q      <= NONE;
            stable_q    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            scan_done_q <= scan_done_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a simulated 4x4 switch matrix plus a scan-level
// reference model of debounce/acceptance (and auto-repeat when the macro is defined).
module tb_keypad_scanner;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 2;
    localparam int unsigned REP    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] pressed = '0;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Reference model state
    int m_prev, m_stable, m_accepted, m_rep;
    logic [3:0] m_code;
    logic       m_held, m_pulse;

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = -1; m_stable = 0; m_accepted = -1; m_rep = 0;
        m_code = 4'd0; m_held = 1'b0; m_pulse = 1'b0;
    endtask

    // One completed scan with a fixed set of pressed keys
    task automatic model_scan(input logic [15:0] keys);
        int res;
        res = -1;
        if ($countones(keys) == 1)
            for (int k = 0; k < 16; k++) if (keys[k]) res = k;
        if (res == m_prev) m_stable = (m_stable < int'(DEB)) ? m_stable + 1 : m_stable;
        else               m_stable = 1;
        m_prev  = res;
        m_pulse = 1'b0;
        if (m_stable >= int'(DEB) && res != m_accepted) begin
            m_accepted = res;
            m_rep      = 0;
            if (res >= 0) begin
                m_code  = 4'(res);
                m_held  = 1'b1;
                m_pulse = 1'b1;
            end else begin
                m_held = 1'b0;
            end
        end else if (m_accepted >= 0) begin
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == int'(REP)) begin
                m_pulse = 1'b1;
                m_rep   = 0;
            end
`endif
        end else begin
            m_rep = 0;
        end
    endtask

    // Runs one 16-cycle scan from a negedge just after a scan boundary
    task automatic run_scan(input logic [15:0] keys, input string tag);
        logic [3:0] ec;
        pressed = keys;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            ec = 4'b1111;
            ec[(i / 4) % 4] = 1'b0;
            check({tag, ":col"}, 8'(col), 8'(ec));
            check({tag, ":valid"}, 8'(key_valid), (i == 1) ? 8'(m_pulse) : 8'd0);
            check({tag, ":held"}, 8'(key_held), 8'(m_held));
            check({tag, ":code"}, 8'(key_code), 8'(m_code));
            if (key_valid) pulses++;
        end
        model_scan(keys);
    endtask

    task automatic run_n(input logic [15:0] keys, input int n, input string tag);
        for (int s = 0; s < n; s++) run_scan(keys, tag);
    endtask

    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K15 = 16'h8000;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] GHOST = 16'h0801;   // key 0 and key 11

    initial begin
        int a, b, hold, kind, cut;
        logic [15:0] pat;

        // Reset state
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst:col", 8'(col), 8'h0e);
        check("rst:code", 8'(key_code), 8'd0);
        check("rst:valid", 8'(key_valid), 8'd0);
        check("rst:held", 8'(key_held), 8'd0);
        reset = 1'b0;
        run_n('0, 3, "idle");

        // Clean press of key 6 for 5 scans, then release
        pulses = 0;
        run_n(K6, 5, "press");
        check("press:held_dir", 8'(key_held), 8'd1);
        check("press:code_dir", 8'(key_code), 8'd6);
        run_n('0, 3, "release");
        check("release:held_dir", 8'(key_held), 8'd0);
        check("release:code_dir", 8'(key_code), 8'd6);
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
        check("press:pulses", 8'(pulses), 8'd2);
`else
        check("press:pulses", 8'(pulses), 8'd1);
`endif

        // Bounce: alternate for 4 scans, then hold
        pulses = 0;
        run_scan(K6, "bounce"); run_scan('0, "bounce");
        run_scan(K6, "bounce"); run_scan('0, "bounce");
        check("bounce:none", 8'(pulses), 8'd0);
        run_n(K6, 3, "bounce_hold");
        check("bounce:one", 8'(pulses), 8'd1);
        check("bounce:code_dir", 8'(key_code), 8'd6);
        run_n('0, 3, "bounce_rel");

        // Ghost / multi-press rejected
        pulses = 0;
        run_n(GHOST, 5, "ghost");
        run_scan('0, "ghost_rel");
        check("ghost:pulses", 8'(pulses), 8'd0);
        check("ghost:held_dir", 8'(key_held), 8'd0);

        // Direct change 6 -> 15 without release
        pulses = 0;
        run_n(K6, 3, "chg6");
        run_n(K15, 3, "chg15");
        check("chg:code_dir", 8'(key_code), 8'd15);
        check("chg:held_dir", 8'(key_held), 8'd1);
        check("chg:pulses", 8'(pulses), 8'd2);
        run_n('0, 3, "chg_rel");

        // Long hold (auto-repeat behaviour depends on build)
        pulses = 0;
        run_n(K6, 12, "hold12");
        run_n('0, 3, "hold_rel");
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
        check("hold12:pulses", 8'(pulses), 8'd4);
`else
        check("hold12:pulses", 8'(pulses), 8'd1);
`endif

        // Random patterns: none, single key or two keys, held for 1..4 scans
        for (int t = 0; t < 12; t++) begin
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 4));
            pat  = '0;
            if (kind == 1 || kind == 2) pat[a] = 1'b1;
            if (kind == 3) begin
                pat[a] = 1'b1;
                pat[b] = 1'b1;
            end
            run_n(pat, hold, "rand");
        end

        // Mid-scan reset during column 2 while key 9 is held
        run_n('0, 3, "pre9");
        run_n(K9, 3, "key9");
        check("key9:code_dir", 8'(key_code), 8'd9);
        cut = int'($urandom_range(9, 11));
        for (int i = 1; i <= cut; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid:col_before", 8'(col), 8'h0b);
        reset = 1'b1;
        #1;
        check("mid:col", 8'(col), 8'h0e);
        check("mid:code", 8'(key_code), 8'd0);
        check("mid:valid", 8'(key_valid), 8'd0);
        check("mid:held", 8'(key_held), 8'd0);
        pressed = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("mid:col_hold", 8'(col), 8'h0e);
        reset = 1'b0;
        run_n('0, 2, "resume");
        pulses = 0;
        run_n(16'h0008, 3, "key3");
        check("key3:code_dir", 8'(key_code), 8'd3);
        check("key3:pulses", 8'(pulses), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
